// File: rtl/core_sequencer_pkg.sv
// Shared types and encodings for the RV32I multi-cycle sequencer.
// Optional feature macro used by core_sequencer: SEQ_PERF_COUNTER_EN.
package core_sequencer_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned NPC_SRC_W = 2;
    localparam int unsigned CAUSE_W   = 2;
    localparam int unsigned PERF_W    = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } seq_state_e;

    localparam logic [NPC_SRC_W-1:0] NEXT_PC_SRC_NONE     = 2'd0;
    localparam logic [NPC_SRC_W-1:0] NEXT_PC_SRC_ALWAYS   = 2'd1;
    localparam logic [NPC_SRC_W-1:0] NEXT_PC_SRC_ZERO     = 2'd2;
    localparam logic [NPC_SRC_W-1:0] NEXT_PC_SRC_NOT_ZERO = 2'd3;

    localparam logic [CAUSE_W-1:0] TRAP_CAUSE_NONE         = 2'd0;
    localparam logic [CAUSE_W-1:0] TRAP_CAUSE_MISALIGNED   = 2'd1;
    localparam logic [CAUSE_W-1:0] TRAP_CAUSE_IMEM_TIMEOUT = 2'd2;
    localparam logic [CAUSE_W-1:0] TRAP_CAUSE_DMEM_TIMEOUT = 2'd3;

    // Resolve the decoder's next-PC select against the ALU zero flag.
    function automatic logic branch_taken(input logic [NPC_SRC_W-1:0] src, input logic zero);
        logic taken;
        case (src)
            NEXT_PC_SRC_ALWAYS:   taken = 1'b1;
            NEXT_PC_SRC_ZERO:     taken = zero;
            NEXT_PC_SRC_NOT_ZERO: taken = ~zero;
            default:              taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/core_sequencer_timeout_ctr.sv
// Bus wait-cycle counter: expired_c flags the last allowed wait cycle so an ack
// arriving in that same cycle still completes the access.
module seq_timeout_ctr
    import core_sequencer_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired_c
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_c = (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the single-issue RV32I core: owns PC and instruction latch,
// sequences fetch/decode/exec/mem/wb and traps. Optional perf counters: SEQ_PERF_COUNTER_EN.
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned     MEM_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_req,
    output logic [XLEN-1:0]      imem_addr,
    input  logic                 imem_ack,
    input  logic [XLEN-1:0]      imem_rdata,
    output logic [XLEN-1:0]      instr,
    output logic [XLEN-1:0]      pc,
    input  logic                 dec_reg_wren,
    input  logic                 dec_ram_wren,
    input  logic                 dec_is_load,
    input  logic [NPC_SRC_W-1:0] dec_next_pc_src,
    input  logic                 alu_zero,
    input  logic [XLEN-1:0]      branch_target,
    output logic                 dmem_req,
    output logic                 dmem_we,
    input  logic                 dmem_ack,
    output logic                 rf_we,
    output logic                 ld_capture,
    output logic                 trap,
`ifdef SEQ_PERF_COUNTER_EN
    output logic [PERF_W-1:0]    cycle_cnt,
    output logic [PERF_W-1:0]    instret_cnt,
`endif
    output logic [CAUSE_W-1:0]   trap_cause
);

    seq_state_e          state_q, state_d;
    logic [XLEN-1:0]     pc_q, pc_d;
    logic [XLEN-1:0]     instr_q, instr_d;
    logic [CAUSE_W-1:0]  cause_q, cause_d;
    logic                tmo_clr, tmo_en, tmo_expired;
    logic                taken, misaligned;

    seq_timeout_ctr #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .clr       (tmo_clr),
        .en        (tmo_en),
        .expired_c (tmo_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            cause_q <= TRAP_CAUSE_NONE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        cause_d    = cause_q;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        rf_we      = 1'b0;
        ld_capture = 1'b0;
        tmo_clr    = 1'b1;
        tmo_en     = 1'b0;
        taken      = branch_taken(dec_next_pc_src, alu_zero);
        misaligned = (branch_target[1:0] != 2'b00);

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                tmo_clr  = 1'b0;
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = ST_DECODE;
                end else begin
                    tmo_en = 1'b1;
                    if (tmo_expired) begin
                        cause_d = TRAP_CAUSE_IMEM_TIMEOUT;
                        state_d = ST_TRAP;
                    end
                end
            end
            ST_DECODE: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = (dec_is_load || dec_ram_wren) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = dec_ram_wren;
                tmo_clr  = 1'b0;
                if (dmem_ack) begin
                    ld_capture = ~dec_ram_wren;
                    state_d    = ST_WB;
                end else begin
                    tmo_en = 1'b1;
                    if (tmo_expired) begin
                        cause_d = TRAP_CAUSE_DMEM_TIMEOUT;
                        state_d = ST_TRAP;
                    end
                end
            end
            ST_WB: begin
                // A taken jump to a non-word target is fatal: no PC or register update.
                if (taken && misaligned) begin
                    cause_d = TRAP_CAUSE_MISALIGNED;
                    state_d = ST_TRAP;
                end else begin
                    rf_we   = dec_reg_wren;
                    pc_d    = taken ? branch_target : (pc_q + XLEN'(4));
                    state_d = ST_FETCH;
                end
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A reset landing on an ack or writeback cycle must not commit anything.
        if (rst) begin
            rf_we      = 1'b0;
            ld_capture = 1'b0;
        end
    end

    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign instr      = instr_q;
    assign trap       = (state_q == ST_TRAP);
    assign trap_cause = cause_q;

`ifdef SEQ_PERF_COUNTER_EN
    logic [PERF_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [PERF_W-1:0] instret_cnt_q, instret_cnt_d;

    always_comb begin
        cycle_cnt_d   = cycle_cnt_q + PERF_W'(1);
        instret_cnt_d = instret_cnt_q;
        if (state_q == ST_WB && state_d == ST_FETCH) begin
            instret_cnt_d = instret_cnt_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`endif

endmodule
